// File: rtl/rd_adc_pkg.sv
// Shared definitions for the ADC serial link: PISO transmitter, SIPO capture and ADC control.
package rd_adc_pkg;

  // Default conversion word length, shared by every block on the link
  localparam int unsigned ADC_WIDTH = 10;

  // Transmitter FSM encoding (kept as plain constants for legacy users)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/rd_piso_tx.sv
// Parallel-in serial-out transmitter: takes one word on Load, shifts it out one bit per CLK
// qualified by SerEn, then pulses Done for one cycle before returning to idle.
module rd_piso_tx
  import rd_adc_pkg::*;
#(
  parameter int unsigned WIDTH      = ADC_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             CLRbar,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load,
  output logic             Ready,
  output logic             SerOut,
  output logic             SerEn,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ser_bit;

  // Next-state: capture on Load in IDLE, shift toward the output end while counting down
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Load) begin
          shreg_d = Din;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        // Leave SHIFT at zero so the counter never wraps
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; CLRbar is an active-high synchronous clear that overrides Load
  always_ff @(posedge CLK) begin
    if (CLRbar) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode from registered state only; SerOut never sees Din combinationally
  always_comb begin
    ser_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    Ready   = (state_q == IDLE);
    Busy    = !Ready;
    SerEn   = (state_q == SHIFT);
    Done    = (state_q == DONE);
    SerOut  = SerEn ? ser_bit : IDLE_LEVEL;
  end

endmodule

// File: tb/tb_rd_piso_tx.sv
// Scoreboard bench for rd_piso_tx: stimulus queues expected bits/words, a monitor pops them
// whenever a DUT presents SerEn or Done. Instance a is MSB-first, instance b is LSB-first.
module tb_rd_piso_tx;

  localparam int W = 10;

  logic         clk;
  logic         clr_a, load_a, clr_b, load_b;
  logic [W-1:0] din_a, din_b;
  logic         ready_a, serout_a, seren_a, busy_a, done_a;
  logic         ready_b, serout_b, seren_b, busy_b, done_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  bit           exp_bits_a[$];
  bit           exp_bits_b[$];
  logic [W-1:0] exp_words_a[$];
  int           exp_done_b = 0;
  int           done_cyc[$];
  logic [W-1:0] sipo_q = '0;

  rd_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
    .CLK    (clk),
    .CLRbar (clr_a),
    .Din    (din_a),
    .Load   (load_a),
    .Ready  (ready_a),
    .SerOut (serout_a),
    .SerEn  (seren_a),
    .Busy   (busy_a),
    .Done   (done_a)
  );

  rd_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut_b (
    .CLK    (clk),
    .CLRbar (clr_b),
    .Din    (din_b),
    .Load   (load_b),
    .Ready  (ready_b),
    .SerOut (serout_b),
    .SerEn  (seren_b),
    .Busy   (busy_b),
    .Done   (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Receiving SIPO model: shifts in at the LSB only when SerEn is high
  always @(posedge clk) if (seren_a) sipo_q <= {sipo_q[W-2:0], serout_a};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue the first nbits of word in MSB-first order, plus the word if a Done is expected
  task automatic push_a(input logic [W-1:0] word, input int nbits, input bit expect_done);
    for (int i = 0; i < nbits; i++) exp_bits_a.push_back(word[W-1-i]);
    if (expect_done) exp_words_a.push_back(word);
  endtask

  task automatic push_b(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) exp_bits_b.push_back(word[i]);
    exp_done_b++;
  endtask

  // Monitor: compare each valid bit and each Done pulse against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a busy_vs_ready", busy_a, !ready_a);
      chk("b busy_vs_ready", busy_b, !ready_b);
      if (!seren_a) chk("a idle_level", serout_a, 0);
      if (seren_a) begin
        if (exp_bits_a.size() == 0) chk("a unexpected_bit", seren_a, 0);
        else chk("a serout_bit", serout_a, exp_bits_a.pop_front());
      end
      if (done_a) begin
        done_cyc.push_back(cyc);
        if (exp_words_a.size() == 0) chk("a unexpected_done", done_a, 0);
        else chk("a sipo_capture", sipo_q, exp_words_a.pop_front());
      end
      if (seren_b) begin
        if (exp_bits_b.size() == 0) chk("b unexpected_bit", seren_b, 0);
        else chk("b serout_bit", serout_b, exp_bits_b.pop_front());
      end
      if (done_b) begin
        if (exp_done_b == 0) chk("b unexpected_done", done_b, 0);
        else exp_done_b--;
      end
    end
  end

  initial begin
    int n;
    clr_a = 1'b1; load_a = 1'b1; din_a = 10'h3FF;
    clr_b = 1'b1; load_b = 1'b1; din_b = 10'h3FF;

    // Reset held with Load asserted: nothing may start
    repeat (2) begin
      @(posedge clk); #2;
      mon_en = 1'b1;
      chk("rst ready", ready_a, 1);
      chk("rst seren", seren_a, 0);
      chk("rst serout", serout_a, 0);
      chk("rst done", done_a, 0);
      chk("rst ready_b", ready_b, 1);
    end
    clr_a = 1'b0; load_a = 1'b0; din_a = '0;
    clr_b = 1'b0; load_b = 1'b0; din_b = '0;
    @(posedge clk); #2;
    chk("post_rst ready", ready_a, 1);

    // MSB-first frame 2B5 with an ignored Load of 000 mid-frame
    push_a(10'h2B5, W, 1'b1);
    load_a = 1'b1; din_a = 10'h2B5;
    @(posedge clk); #1;
    load_a = 1'b0; din_a = 10'h0F0;
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin load_a = 1'b1; din_a = 10'h000; end
      if (i == 3) load_a = 1'b0;
    end
    #1;
    chk("frame done_timing", done_a, 1);
    chk("frame ready_in_done", ready_a, 0);
    @(posedge clk); #2;
    chk("frame done_single", done_a, 0);
    chk("frame ready_back", ready_a, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("no_second_frame", ready_a, 1);

    // Mid-frame reset during bit 4 of 2B5: only bits 0..4 go out, no Done
    push_a(10'h2B5, 5, 1'b0);
    load_a = 1'b1; din_a = 10'h2B5;
    @(posedge clk); #1;
    load_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0; #1;
    chk("abort seren", seren_a, 0);
    chk("abort serout", serout_a, 0);
    chk("abort ready", ready_a, 1);
    chk("abort done", done_a, 0);
    repeat (14) @(posedge clk);
    #2;
    chk("abort still_idle", ready_a, 1);

    // Loopback: three words with Load held high, accepted every 12 cycles
    push_a(10'h155, W, 1'b1);
    push_a(10'h2AA, W, 1'b1);
    push_a(10'h3C1, W, 1'b1);
    load_a = 1'b1; din_a = 10'h155;
    @(posedge clk); #1;
    din_a = 10'h2AA;
    repeat (12) @(posedge clk);
    #1;
    din_a = 10'h3C1;
    repeat (12) @(posedge clk);
    #1;
    load_a = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    n = done_cyc.size();
    chk("loop done_count", n, 4);
    if (n >= 3) begin
      chk("loop spacing_1", done_cyc[n-2] - done_cyc[n-3], 12);
      chk("loop spacing_2", done_cyc[n-1] - done_cyc[n-2], 12);
    end

    // LSB-first frame on instance b
    push_b(10'h3C1);
    load_b = 1'b1; din_b = 10'h3C1;
    @(posedge clk); #1;
    load_b = 1'b0; din_b = '0;
    repeat (W) @(posedge clk);
    #2;
    chk("b done_timing", done_b, 1);
    @(posedge clk); #2;
    chk("b ready_back", ready_b, 1);
    repeat (3) @(posedge clk);
    #2;

    chk("a bits_left", exp_bits_a.size(), 0);
    chk("a words_left", exp_words_a.size(), 0);
    chk("b bits_left", exp_bits_b.size(), 0);
    chk("b dones_left", exp_done_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
